// File: rtl/quire_norm_pkg.sv
// Shared types and helpers for the quire normalizer pipeline.
// The default widths here fix the layout of norm_out_t used by quire_norm_pipe.
package quire_norm_pkg;

    localparam int QUIRE_W_DEF    = 64;
    localparam int FRAC_POINT_DEF = 32;
    localparam int FRAC_W_DEF     = 16;
    localparam int EXP_W          = $clog2(QUIRE_W_DEF) + 1;
    localparam int IDX_W          = $clog2(QUIRE_W_DEF);

    typedef struct packed {
        logic                    sign;
        logic [EXP_W-1:0]        exp;
        logic [FRAC_W_DEF-1:0]   frac;
        logic                    guard;
        logic                    sticky;
        logic                    zero;
    } norm_out_t;

    // MSB-priority scan: later (higher) hits overwrite earlier ones; returns 0 for mag==0
    function automatic logic [IDX_W-1:0] lead_one_idx(input logic [QUIRE_W_DEF-1:0] mag);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < QUIRE_W_DEF; i++) begin
            if (mag[i]) begin
                idx = IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/quire_norm_pipe_barrel_shift.sv
// Combinational log-depth left shifter: one mux layer per bit of the shift amount.
module norm_barrel_shift #(
    parameter int W    = 64,
    parameter int SH_W = $clog2(W)
) (
    input  logic [W-1:0]    mag,
    input  logic [SH_W-1:0] amount,
    output logic [W-1:0]    sh
);

    logic [SH_W:0][W-1:0] stage_w;

    assign stage_w[0] = mag;

    genvar gi;
    generate
        for (gi = 0; gi < SH_W; gi++) begin : g_stage
            assign stage_w[gi+1] = amount[gi] ? (stage_w[gi] << (1 << gi)) : stage_w[gi];
        end
    endgenerate

    assign sh = stage_w[SH_W];

endmodule

// File: rtl/quire_norm_pipe.sv
// Three-stage quire normalizer (magnitude, leading-one, align) with a global stall.
// Build option: QUIRE_NORM_STICKY_EN enables the sticky OR-reduce; otherwise m_sticky is tied 0.
module quire_norm_pipe
    import quire_norm_pkg::*;
#(
    parameter int QUIRE_W    = QUIRE_W_DEF,
    parameter int FRAC_POINT = FRAC_POINT_DEF,
    parameter int FRAC_W     = FRAC_W_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [QUIRE_W-1:0]               s_data,
    input  logic                             s_valid,
    output logic                             s_ready,
    output logic                             m_sign,
    output logic [$clog2(QUIRE_W):0]         m_exp,
    output logic [FRAC_W-1:0]                m_frac,
    output logic                             m_guard,
    output logic                             m_sticky,
    output logic                             m_zero,
    output logic                             m_valid,
    input  logic                             m_ready
);

    localparam int SH_W = $clog2(QUIRE_W);

    logic                 stall;
    logic                 s1_valid_reg, s1_sign_reg;
    logic [QUIRE_W-1:0]   s1_mag_reg, s1_mag_next;
    logic                 s2_valid_reg, s2_sign_reg, s2_zero_reg;
    logic [QUIRE_W-1:0]   s2_mag_reg;
    logic [SH_W-1:0]      s2_lead_reg, s2_lead_next;
    logic [EXP_W-1:0]     s2_exp_reg, s2_exp_next;
    logic                 s3_valid_reg;
    norm_out_t            s3_reg, s3_next;
    logic [SH_W-1:0]      shift_amt;
    logic [QUIRE_W-1:0]   sh;

    assign stall   = s3_valid_reg & ~m_ready;
    assign s_ready = ~stall;

    // Two's-complement negate; the most-negative input maps to 2^(QUIRE_W-1) unsigned
    assign s1_mag_next  = s_data[QUIRE_W-1] ? (~s_data + QUIRE_W'(1)) : s_data;
    assign s2_lead_next = lead_one_idx(s1_mag_reg);
    assign s2_exp_next  = (s1_mag_reg == '0) ? '0
                        : ({1'b0, s2_lead_next} - EXP_W'(FRAC_POINT));

    assign shift_amt = SH_W'(QUIRE_W - 1) - s2_lead_reg;

    norm_barrel_shift #(
        .W    (QUIRE_W),
        .SH_W (SH_W)
    ) u_shift (
        .mag    (s2_mag_reg),
        .amount (shift_amt),
        .sh     (sh)
    );

    // The hidden one lands in sh[QUIRE_W-1] and is dropped
`ifdef QUIRE_NORM_STICKY_EN
    logic unused_sh;
    assign unused_sh = sh[QUIRE_W-1];
`else
    logic unused_sh;
    assign unused_sh = ^{sh[QUIRE_W-1], sh[QUIRE_W-3-FRAC_W:0]};
`endif

    always_comb begin
        s3_next        = '0;
        s3_next.sign   = s2_sign_reg;
        s3_next.exp    = s2_exp_reg;
        s3_next.frac   = sh[QUIRE_W-2 -: FRAC_W];
        s3_next.guard  = sh[QUIRE_W-2-FRAC_W];
`ifdef QUIRE_NORM_STICKY_EN
        s3_next.sticky = |sh[QUIRE_W-3-FRAC_W:0];
`else
        s3_next.sticky = 1'b0;
`endif
        s3_next.zero   = s2_zero_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_mag_reg   <= '0;
            s2_valid_reg <= 1'b0;
            s2_sign_reg  <= 1'b0;
            s2_zero_reg  <= 1'b0;
            s2_mag_reg   <= '0;
            s2_lead_reg  <= '0;
            s2_exp_reg   <= '0;
            s3_valid_reg <= 1'b0;
            s3_reg       <= '0;
        end else if (!stall) begin
            s1_valid_reg <= s_valid;
            s1_sign_reg  <= s_data[QUIRE_W-1];
            s1_mag_reg   <= s1_mag_next;
            s2_valid_reg <= s1_valid_reg;
            s2_sign_reg  <= s1_sign_reg;
            s2_zero_reg  <= (s1_mag_reg == '0);
            s2_mag_reg   <= s1_mag_reg;
            s2_lead_reg  <= s2_lead_next;
            s2_exp_reg   <= s2_exp_next;
            s3_valid_reg <= s2_valid_reg;
            s3_reg       <= s3_next;
        end
    end

    assign m_valid  = s3_valid_reg;
    assign m_sign   = s3_reg.sign;
    assign m_exp    = s3_reg.exp;
    assign m_frac   = s3_reg.frac;
    assign m_guard  = s3_reg.guard;
    assign m_sticky = s3_reg.sticky;
    assign m_zero   = s3_reg.zero;

endmodule

// File: tb/tb_quire_norm_pipe.sv
// Scoreboard bench for quire_norm_pipe (64-bit quire, 32 fraction bits, 16-bit fraction out).
module tb_quire_norm_pipe;

    typedef struct packed {
        logic        sign;
        logic [6:0]  exp;
        logic [15:0] frac;
        logic        guard;
        logic        sticky;
        logic        zero;
    } exp_t;

`ifdef QUIRE_NORM_STICKY_EN
    localparam logic STICKY_ON = 1'b1;
`else
    localparam logic STICKY_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        m_sign;
    logic [6:0]  m_exp;
    logic [15:0] m_frac;
    logic        m_guard;
    logic        m_sticky;
    logic        m_zero;
    logic        m_valid;
    logic        m_ready;

    int   n_checks = 0;
    int   n_errors = 0;
    int   out_cnt  = 0;
    int   max_occ  = 0;
    bit   saw_stall = 1'b0;
    exp_t cur_exp;
    exp_t mon_e;
    exp_t sb[$];

    always #5 clk = ~clk;

    quire_norm_pipe dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .m_sign   (m_sign),
        .m_exp    (m_exp),
        .m_frac   (m_frac),
        .m_guard  (m_guard),
        .m_sticky (m_sticky),
        .m_zero   (m_zero),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic sg, input int e, input logic [15:0] fr,
                                input logic gd, input logic st, input logic zr);
        exp_t r;
        r.sign = sg; r.exp = 7'(e); r.frac = fr; r.guard = gd; r.sticky = st; r.zero = zr;
        return r;
    endfunction

    // Bit-picking reference: reads fraction bits straight out of the magnitude
    function automatic exp_t model(input logic [63:0] d);
        exp_t r;
        logic [63:0] mag;
        int lead;
        int pos;
        r = '0;
        r.sign = d[63];
        mag = d[63] ? (~d + 64'd1) : d;
        if (mag == 64'd0) begin
            r.zero = 1'b1;
            r.sign = 1'b0;
            return r;
        end
        lead = 0;
        for (int i = 63; i >= 0; i--) begin
            if (mag[i]) begin lead = i; break; end
        end
        r.exp = 7'(lead - 32);
        for (int j = 0; j < 16; j++) begin
            pos = lead - 1 - j;
            r.frac[15-j] = (pos >= 0) ? mag[pos] : 1'b0;
        end
        pos = lead - 17;
        r.guard = (pos >= 0) ? mag[pos] : 1'b0;
        for (int k = 0; k < lead - 17; k++) begin
            if (mag[k]) r.sticky = STICKY_ON;
        end
        return r;
    endfunction

    // Negedge monitor: handshakes seen here commit at the next rising edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (!s_ready) saw_stall = 1'b1;
            if (m_valid && m_ready) begin
                if (sb.size() == 0) begin
                    check_val("extra_out", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val($sformatf("out%0d.sign", out_cnt),   64'(m_sign),   64'(mon_e.sign));
                    check_val($sformatf("out%0d.exp", out_cnt),    64'(m_exp),    64'(mon_e.exp));
                    check_val($sformatf("out%0d.frac", out_cnt),   64'(m_frac),   64'(mon_e.frac));
                    check_val($sformatf("out%0d.guard", out_cnt),  64'(m_guard),  64'(mon_e.guard));
                    check_val($sformatf("out%0d.sticky", out_cnt), 64'(m_sticky), 64'(mon_e.sticky));
                    check_val($sformatf("out%0d.zero", out_cnt),   64'(m_zero),   64'(mon_e.zero));
                end
                $display("out %0d: sign=%0b exp=%0d frac=%h g=%0b s=%0b z=%0b", out_cnt,
                         m_sign, $signed(m_exp), m_frac, m_guard, m_sticky, m_zero);
                out_cnt++;
            end
            if (s_valid && s_ready) sb.push_back(cur_exp);
            if (sb.size() > max_occ) max_occ = sb.size();
        end
    end

    task automatic send(input logic [63:0] d, input exp_t e);
        bit acc;
        int t;
        acc = 1'b0;
        t = 0;
        s_data  = d;
        cur_exp = e;
        s_valid = 1'b1;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            t++;
        end
        s_valid = 1'b0;
        if (!acc) check_val("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        m_ready = 1'b1;
        while (sb.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_val("drain_empty", 64'(sb.size()), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        int start_cnt;
        logic [63:0] v;
        rst_n   = 1'b0;
        s_data  = '0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        cur_exp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst.m_valid", 64'(m_valid), 64'd0);
        check_val("rst.s_ready", 64'(s_ready), 64'd1);
        check_val("rst.m_frac",  64'(m_frac),  64'd0);
        check_val("rst.m_exp",   64'(m_exp),   64'd0);
        check_val("rst.m_zero",  64'(m_zero),  64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst.s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        // Directed vectors with hand-derived expectations
        send(64'h0000_0001_0000_0000, mk(1'b0,   0, 16'h0000, 1'b0, 1'b0,      1'b0));
        send(64'hFFFF_FFFE_8000_0000, mk(1'b1,   0, 16'h8000, 1'b0, 1'b0,      1'b0));
        send(64'h0000_0000_0000_0000, mk(1'b0,   0, 16'h0000, 1'b0, 1'b0,      1'b1));
        send(64'h8000_0000_0000_0000, mk(1'b1,  31, 16'h0000, 1'b0, 1'b0,      1'b0));
        send(64'h0000_0000_0000_0007, mk(1'b0, -30, 16'hC000, 1'b0, 1'b0,      1'b0));
        send(64'h0000_0001_0000_0001, mk(1'b0,   0, 16'h0000, 1'b0, STICKY_ON, 1'b0));
        send(64'h0000_0000_0000_0001, mk(1'b0, -32, 16'h0000, 1'b0, 1'b0,      1'b0));
        send(64'h7FFF_FFFF_FFFF_FFFF, mk(1'b0,  30, 16'hFFFF, 1'b1, STICKY_ON, 1'b0));
        drain();

        // Back-to-back stream of 8 with the consumer stalled for cycles 4-8
        saw_stall = 1'b0;
        max_occ   = 0;
        start_cnt = out_cnt;
        done      = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    v = {32'(i + 1), 32'h1234_5678 >> i};
                    if (i[0]) v = ~v + 64'd1;
                    send(v, model(v));
                end
                done = 1'b1;
            end
            begin
                for (int c = 1; c <= 30; c++) begin
                    m_ready = !(c >= 4 && c <= 8);
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        drain();
        check_val("stream.count",    64'(out_cnt - start_cnt), 64'd8);
        check_val("stream.s_ready_dropped", 64'(saw_stall), 64'd1);
        check_val("stream.capacity", 64'(max_occ), 64'd3);

        // Random values, random gaps and random consumer back-pressure
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    v = {$urandom, $urandom};
                    case ($urandom_range(0, 3))
                        0: v = v >> $urandom_range(0, 63);
                        1: v = ~(v >> $urandom_range(1, 63)) + 64'd1;
                        default: ;
                    endcase
                    send(v, model(v));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    m_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                m_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with two items in flight
        m_ready = 1'b1;
        send(64'h0000_0002_0000_0000, model(64'h0000_0002_0000_0000));
        send(64'h0000_0003_0000_0000, model(64'h0000_0003_0000_0000));
        @(posedge clk);
        #1;
        check_val("pre_rst.m_valid", 64'(m_valid), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_rst.m_valid", 64'(m_valid), 64'd0);
        check_val("async_rst.s_ready", 64'(s_ready), 64'd1);
        sb.delete();
        start_cnt = out_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check_val("stale_outputs", 64'(out_cnt - start_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
